// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and width limits for the serial adder/subtractor
package serial_addsub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: single combinational full-adder cell
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub_core.sv
// serial_addsub_core: LSB-first bit-serial add/subtract/accumulate with start/busy/done handshake
module serial_addsub_core
  import serial_addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  state_t           state, next;
  logic [WIDTH-1:0] op_a, op_b, shifted;
  logic [WIDTH-2:0] res;
  logic [CNT_W-1:0] cnt;
  logic             carry, s_bit, c_bit, last;
  full_adder_bit u_fa (
    .a   (op_a[0]),
    .b   (op_b[0]),
    .cin (carry),
    .s   (s_bit),
    .cout(c_bit)
  );
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    last    = cnt == CNT_W'(WIDTH - 1);
    shifted = {s_bit, res};
    next    = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res   <= shifted[WIDTH-1:1];
      carry <= c_bit;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= shifted;
        cout <= c_bit;
        ovf  <= carry ^ c_bit;
      end
    end else if (start) begin
      op_a  <= acc ? sum : a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end
  end
endmodule

// File: tb/tb_serial_addsub_core.sv
// tb_serial_addsub_core: directed and random checks of four widths against an arithmetic model
module tb_serial_addsub_core;
  function automatic int wof(int g);
    return g == 0 ? 8 : g == 1 ? 2 : g == 2 ? 16 : 32;
  endfunction
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start, sub, acc;
  logic [31:0] a_v [4];
  logic [31:0] b_v [4];
  wire  [31:0] sum_v [4];
  wire  [3:0]  busy, done, cout, ovf;
  logic [63:0] mdl_sum [4];
  int          total = 0;
  int          passed = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int W = wof(g);
    wire [W-1:0] s;
    serial_addsub_core #(.WIDTH(W)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start[g]),
      .sub  (sub[g]),
      .acc  (acc[g]),
      .a    (a_v[g][W-1:0]),
      .b    (b_v[g][W-1:0]),
      .busy (busy[g]),
      .done (done[g]),
      .sum  (s),
      .cout (cout[g]),
      .ovf  (ovf[g])
    );
    assign sum_v[g] = 32'(s);
  end
  task automatic check(string tag, int g, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s w=%0d observed=%0h expected=%0h", tag, wof(g), obs, exp);
  endtask
  function automatic void model(int w, bit s, logic [63:0] x, logic [63:0] y,
                                output logic [63:0] r, output bit co, output bit ov);
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint half = longint'(1) << (w - 1);
    longint full = longint'(1) << w;
    longint sx = ux >= half ? ux - full : ux;
    longint sy = uy >= half ? uy - full : uy;
    longint rs = s ? sx - sy : sx + sy;
    r  = 64'((s ? ux - uy : ux + uy) & (full - 1));
    co = s ? ux >= uy : ux + uy >= full;
    ov = rs < -half || rs > half - 1;
  endfunction
  task automatic run_op(int g, bit s, bit ac, logic [31:0] x, logic [31:0] y, int intr, string tag);
    int          w = wof(g);
    logic [63:0] m = (64'd1 << w) - 1;
    logic [63:0] opa = ac ? mdl_sum[g] : 64'(x) & m;
    logic [63:0] r;
    bit          co, ov;
    model(w, s, opa, 64'(y) & m, r, co, ov);
    sub[g] = s;
    acc[g] = ac;
    a_v[g] = x;
    b_v[g] = y;
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    sub[g] = ~s;
    acc[g] = ~ac;
    a_v[g] = $urandom;
    b_v[g] = $urandom;
    for (int c = 1; c <= w; c++) begin
      if (c == intr) begin
        start[g] = 1'b1;
        a_v[g] = $urandom;
        b_v[g] = $urandom;
      end
      @(negedge clk);
      check({tag, "_busy"}, g, 64'(busy[g]), 64'd1);
      check({tag, "_nodone"}, g, 64'(done[g]), 64'd0);
      check({tag, "_hold"}, g, 64'(sum_v[g]), mdl_sum[g]);
      @(posedge clk);
      #1;
      start[g] = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done"}, g, 64'(done[g]), 64'd1);
    check({tag, "_idlebusy"}, g, 64'(busy[g]), 64'd0);
    check({tag, "_sum"}, g, 64'(sum_v[g]), r);
    check({tag, "_cout"}, g, 64'(cout[g]), 64'(co));
    check({tag, "_ovf"}, g, 64'(ovf[g]), 64'(ov));
    mdl_sum[g] = r;
  endtask
  task automatic idle(int g);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_done", g, 64'(done[g]), 64'd0);
    check("idle_busy", g, 64'(busy[g]), 64'd0);
    check("idle_sum", g, 64'(sum_v[g]), mdl_sum[g]);
  endtask
  initial begin
    rst_n = 1'b0;
    start = '0;
    sub = '0;
    acc = '0;
    for (int g = 0; g < 4; g++) begin
      a_v[g] = '0;
      b_v[g] = '0;
      mdl_sum[g] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("rst_busy", g, 64'(busy[g]), 64'd0);
      check("rst_done", g, 64'(done[g]), 64'd0);
      check("rst_sum", g, 64'(sum_v[g]), 64'd0);
      check("rst_cout", g, 64'(cout[g]), 64'd0);
      check("rst_ovf", g, 64'(ovf[g]), 64'd0);
    end
    rst_n = 1'b1;
    run_op(0, 0, 0, 32'h5A, 32'h3C, 0, "add");
    idle(0);
    run_op(0, 0, 0, 32'hFF, 32'h01, 0, "wrap");
    idle(0);
    run_op(0, 1, 0, 32'h10, 32'h20, 0, "borrow");
    idle(0);
    run_op(0, 1, 0, 32'h80, 32'h01, 0, "subovf");
    idle(0);
    run_op(0, 0, 0, 32'h5A, 32'h3C, 0, "pre_acc");
    run_op(0, 0, 1, 32'hFF, 32'h0A, 0, "acc_b2b");
    idle(0);
    run_op(0, 0, 0, 32'h12, 32'h34, 3, "ignore");
    idle(0);
    sub[0] = 1'b0;
    acc[0] = 1'b0;
    a_v[0] = 32'h33;
    b_v[0] = 32'h44;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) mdl_sum[g] = '0;
    @(negedge clk);
    check("mid_busy", 0, 64'(busy[0]), 64'd0);
    check("mid_done", 0, 64'(done[0]), 64'd0);
    check("mid_sum", 0, 64'(sum_v[0]), 64'd0);
    check("mid_cout", 0, 64'(cout[0]), 64'd0);
    check("mid_ovf", 0, 64'(ovf[0]), 64'd0);
    repeat (10) begin
      @(negedge clk);
      check("mid_nodone", 0, 64'(done[0]), 64'd0);
    end
    run_op(0, 0, 1, 32'hFF, 32'h07, 0, "acc_zero");
    idle(0);
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 8; i++) begin
        run_op(g, 1'($urandom), 1'($urandom), $urandom, $urandom, 0, "rand");
        if ($urandom_range(1, 0) == 1) idle(g);
      end
      idle(g);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
